wc_z_serializer: RTL and testbench

- Output-side counterpart to the Winograd F(4,3) core input path. The core consumes six parallel 10-bit samples on D and produces one tile of four 10-bit results on Z.
- This block accepts one parallel Z tile per handshake, buffers up to DEPTH tiles, and transmits the words serially, one per beat, on a valid/ready stream.
- It sits between the WC core and the narrow output pad ring, so the 40 output pads can be reduced to W data pads plus control.

---
 rtl/wc_z_serializer_pkg.sv | 22 ++
 rtl/wc_z_serializer_if.sv | 32 +++
 rtl/wc_z_serializer_fifo.sv | 65 ++++++
 rtl/wc_z_serializer.sv | 91 +++++++++
 tb/tb_wc_z_serializer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/wc_z_serializer_pkg.sv
// Shared constants and types for the Winograd Z-tile serializer.
// The W/N/TID_W defaults are also used by the WC core and pad wrapper.
package wc_z_serializer_pkg;

  localparam int W_DEF     = 10;
  localparam int N_DEF     = 4;
  localparam int TID_W_DEF = 8;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } ser_state_e;

  // Word k of a tile sits at bits [k*W +: W], word 0 in the LSBs.
  function automatic logic [W_DEF-1:0] word_sel(
    input logic [N_DEF*W_DEF-1:0] tile,
    input int unsigned            k
  );
    return tile[k*W_DEF +: W_DEF];
  endfunction

endpackage

// File: rtl/wc_z_serializer_if.sv
// Tile-in / word-out stream bundle of the Z serializer.
// slave is the serializer side, master the core/pad side.
interface wc_z_serializer_if
  import wc_z_serializer_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int N     = N_DEF,
  parameter int TID_W = TID_W_DEF
);

  logic             z_valid;
  logic             z_ready;
  logic [N*W-1:0]   z_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             out_last;
  logic [TID_W-1:0] out_tid;

  modport master (
    output z_valid, z_data, out_ready,
    input  z_ready, out_valid, out_data,
    input  out_last, out_tid
  );

  modport slave (
    input  z_valid, z_data, out_ready,
    output z_ready, out_valid, out_data,
    output out_last, out_tid
  );

endinterface

// File: rtl/wc_z_serializer_fifo.sv
// DEPTH-entry tile buffer with occupancy count.
// Caller guarantees no push when full and no pop when empty.
module wc_tile_fifo
  import wc_z_serializer_pkg::*;
#(
  parameter  int DW    = N_DEF * W_DEF,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/wc_z_serializer.sv
// Buffers parallel Z tiles and streams them out one word per beat,
// word 0 first, with a per-tile sequence number.
module wc_z_serializer
  import wc_z_serializer_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int N     = N_DEF,
  parameter int DEPTH = 2,
  parameter int TID_W = TID_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  wc_z_serializer_if.slave zif,
  output logic             busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int XW = (N > 1) ? $clog2(N) : 1;
  localparam logic [XW-1:0] LAST_IDX = XW'(N - 1);

  ser_state_e       state_q, state_d;
  logic [XW-1:0]    widx_q, widx_d;
  logic [TID_W-1:0] tid_q, tid_d;

  logic           push, pop, beat, at_last;
  logic [N*W-1:0] tile;
  logic [CW-1:0]  count;
  logic           full, empty;

  wc_tile_fifo #(
    .DW    (N * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (zif.z_data),
    .pop_i   (pop),
    .rdata_o (tile),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Registered occupancy only; a same-cycle pop never frees the slot.
  assign zif.z_ready = rst & ~full;
  assign push        = zif.z_valid & zif.z_ready;

  assign zif.out_valid = (state_q == S_SEND);
  assign beat          = zif.out_valid & zif.out_ready;
  assign at_last       = (widx_q == LAST_IDX);
  assign pop           = beat & at_last;

  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    tid_d   = tid_q;
    unique case (state_q)
      S_IDLE: begin
        if (push) state_d = S_SEND;
      end
      S_SEND: begin
        if (pop) begin
          widx_d = '0;
          tid_d  = tid_q + 1'b1;
          if (count == CW'(1) && !push) state_d = S_IDLE;
        end else if (beat) begin
          widx_d = widx_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      widx_q  <= '0;
      tid_q   <= '0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      tid_q   <= tid_d;
    end
  end

  assign zif.out_data = zif.out_valid ? tile[int'(widx_q) * W +: W] : '0;
  assign zif.out_last = zif.out_valid & at_last;
  assign zif.out_tid  = tid_q;
  assign busy         = ~empty;

endmodule

// File: tb/tb_wc_z_serializer.sv
// Scoreboard bench for wc_z_serializer: directed cases plus random
// traffic, checked against a word-queue model of the tile stream.
module tb_wc_z_serializer;

  localparam int W     = 10;
  localparam int N     = 4;
  localparam int DEPTH = 2;
  localparam int TID_W = 8;

  typedef struct {
    logic [W-1:0]     w;
    logic             last;
    logic [TID_W-1:0] tid;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;

  int checks   = 0;
  int failures = 0;

  exp_t             exp_q[$];
  logic [TID_W-1:0] acc_tid  = '0;
  logic [TID_W-1:0] done_tid = '0;

  wc_z_serializer_if #(.W(W), .N(N), .TID_W(TID_W)) zif ();

  wc_z_serializer #(
    .W     (W),
    .N     (N),
    .DEPTH (DEPTH),
    .TID_W (TID_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .zif  (zif),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares on the falling edge, then applies the
  // handshakes that the next rising edge will complete.
  initial begin : monitor
    int   tiles;
    exp_t e;
    forever begin
      @(negedge clk or negedge rst);
      if (!rst) begin
        exp_q.delete();
        acc_tid  = '0;
        done_tid = '0;
        #1;
        chk("rst_out_valid", 64'(zif.out_valid), '0);
        chk("rst_out_data",  64'(zif.out_data),  '0);
        chk("rst_out_last",  64'(zif.out_last),  '0);
        chk("rst_out_tid",   64'(zif.out_tid),   '0);
        chk("rst_z_ready",   64'(zif.z_ready),   '0);
        chk("rst_busy",      64'(busy),          '0);
      end else begin
        tiles = (exp_q.size() + N - 1) / N;
        chk("out_valid", 64'(zif.out_valid), 64'(exp_q.size() != 0));
        chk("busy",      64'(busy),          64'(tiles != 0));
        chk("z_ready",   64'(zif.z_ready),   64'(tiles < DEPTH));
        if (zif.out_valid && exp_q.size() != 0) begin
          chk("out_data", 64'(zif.out_data), 64'(exp_q[0].w));
          chk("out_last", 64'(zif.out_last), 64'(exp_q[0].last));
          chk("out_tid",  64'(zif.out_tid),  64'(exp_q[0].tid));
        end else if (!zif.out_valid) begin
          chk("idle_data", 64'(zif.out_data), '0);
          chk("idle_last", 64'(zif.out_last), '0);
          chk("idle_tid",  64'(zif.out_tid),  64'(done_tid));
        end
        if (zif.out_valid && zif.out_ready && exp_q.size() != 0) begin
          if (exp_q[0].last) done_tid++;
          void'(exp_q.pop_front());
        end
        if (zif.z_valid && zif.z_ready) begin
          for (int k = 0; k < N; k++) begin
            e.w    = W'(zif.z_data >> (k * W));
            e.last = (k == N - 1);
            e.tid  = acc_tid;
            exp_q.push_back(e);
          end
          acc_tid++;
        end
      end
    end
  end

  function automatic logic [N*W-1:0] rnd_tile();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[N*W-1:0];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic send_tile(input logic [N*W-1:0] t);
    logic acc;
    int   n;
    n = 0;
    zif.z_valid = 1'b1;
    zif.z_data  = t;
    do begin
      @(negedge clk);
      acc = zif.z_ready;
      cyc();
      n++;
    end while (!acc && n < 200);
    zif.z_valid = 1'b0;
    if (!acc) begin
      $display("FAIL send_timeout: z_ready stuck low, 0 accepts");
      $fatal(1, "send timeout");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      cyc();
      n++;
    end
    if (exp_q.size() != 0) begin
      $display("FAIL drain_timeout: %0d words pending, 0 required",
               exp_q.size());
      $fatal(1, "drain timeout");
    end
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
  endtask

  initial begin : stim
    int n;
    zif.z_valid   = 1'b0;
    zif.z_data    = '0;
    zif.out_ready = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;
    cyc();

    // Single known tile: beats 001, 2AA, 155, 3FF.
    zif.out_ready = 1'b1;
    send_tile({10'h3FF, 10'h155, 10'h2AA, 10'h001});
    drain();

    // Back-to-back tiles with the sink always ready.
    for (int i = 0; i < 3; i++) send_tile(rnd_tile());
    drain();

    // Five-cycle stall while word 1 is presented.
    send_tile(rnd_tile());
    cyc();
    zif.out_ready = 1'b0;
    repeat (5) cyc();
    zif.out_ready = 1'b1;
    drain();

    // Fill the buffer, then free a slot while a third tile waits.
    zif.out_ready = 1'b0;
    send_tile(rnd_tile());
    send_tile(rnd_tile());
    fork
      send_tile(rnd_tile());
      begin
        repeat (3) cyc();
        zif.out_ready = 1'b1;
      end
    join
    send_tile(rnd_tile());
    drain();

    // Random traffic on both sides.
    for (int i = 0; i < 400; i++) begin
      zif.z_valid   = 1'($urandom_range(0, 1));
      zif.z_data    = rnd_tile();
      zif.out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    zif.z_valid   = 1'b0;
    zif.out_ready = 1'b1;
    drain();

    // Reset right after word 1 of tile 5 has been taken.
    do_reset();
    for (int i = 0; i < 6; i++) send_tile(rnd_tile());
    n = 0;
    while (!(exp_q.size() == N - 2 && exp_q[0].tid == TID_W'(5))
           && n < 100) begin
      cyc();
      n++;
    end
    if (n >= 100) begin
      $display("FAIL tile5_wait: word 1 of tile 5 not seen in 100 cycles");
      $fatal(1, "wait timeout");
    end
    rst = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    send_tile(rnd_tile());
    drain();

    // Sequence-number wrap across 257 tiles.
    do_reset();
    for (int i = 0; i < 257; i++) send_tile(rnd_tile());
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
